// File: rtl/result_packer.sv
// Packs signed datapath results into 8-bit lanes of 32-bit words, with optional ReLU and
// saturation, and queues each word with its output-buffer address in a small FIFO.
module result_packer #(
  parameter int RESULT_DWIDTH = 20,
  parameter int ADDR_WIDTH    = 12,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic                     en_relu,
  input  logic [RESULT_DWIDTH-1:0] result_data,
  input  logic                     result_valid,
  input  logic                     flush,
  output logic [31:0]              wr_data,
  output logic [3:0]               wr_strb,
  output logic [ADDR_WIDTH-1:0]    wr_addr,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic                     sat_flag,
  output logic                     fifo_ovrflow,
  output logic                     done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic signed [RESULT_DWIDTH-1:0] MAX_V = RESULT_DWIDTH'(127);
  localparam logic signed [RESULT_DWIDTH-1:0] MIN_V = RESULT_DWIDTH'(-128);

  logic [1:0]            lane_q, lane_d;
  logic [31:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  sat_q, sat_d;
  logic                  ovf_q, ovf_d;
  logic                  flush_seen_q, flush_seen_d;
  logic                  done_q, done_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [35:0]           mem_q [FIFO_DEPTH];
  logic [35:0]           mem_d [FIFO_DEPTH];

  logic signed [RESULT_DWIDTH-1:0] relu_v;
  logic [7:0]  conv_byte;
  logic        conv_sat;
  logic        take, do_flush, pop, push, full;
  logic [31:0] packed_word, push_word;
  logic [3:0]  push_strb;
  logic [2:0]  k;

  always_comb begin
    relu_v = $signed(result_data);
    if (en_relu && result_data[RESULT_DWIDTH-1]) relu_v = '0;
    conv_sat  = 1'b0;
    conv_byte = relu_v[7:0];
    if (relu_v > MAX_V) begin
      conv_byte = 8'h7F;
      conv_sat  = 1'b1;
    end else if (relu_v < MIN_V) begin
      conv_byte = 8'h80;
      conv_sat  = 1'b1;
    end
  end

  assign wr_valid = (count_q != '0);
  assign {wr_strb, wr_data} = mem_q[rd_ptr_q];
  assign wr_addr      = addr_q;
  assign sat_flag     = sat_q;
  assign fifo_ovrflow = ovf_q;
  assign done         = done_q;

  always_comb begin
    lane_d       = lane_q;
    word_d       = word_q;
    addr_d       = addr_q;
    sat_d        = sat_q;
    ovf_d        = ovf_q;
    flush_seen_d = flush_seen_q;
    done_d       = done_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    mem_d        = mem_q;
    push         = 1'b0;
    push_word    = '0;
    push_strb    = '0;

    take     = result_valid & ~start;
    do_flush = flush & ~start;
    pop      = wr_valid & wr_ready;
    full     = (count_q == CNT_W'(FIFO_DEPTH));

    // The incoming byte is merged before any flush so a same-cycle flush includes it.
    packed_word = word_q;
    if (take) begin
      packed_word[{lane_q, 3'b000} +: 8] = conv_byte;
      sat_d = sat_q | conv_sat;
    end
    k = {1'b0, lane_q} + 3'(take);

    if (k == 3'd4) begin
      push      = 1'b1;
      push_word = packed_word;
      push_strb = 4'b1111;
      lane_d    = 2'd0;
      word_d    = '0;
    end else if (do_flush && (k != 3'd0)) begin
      push      = 1'b1;
      push_word = packed_word;
      case (k)
        3'd1:    push_strb = 4'b0001;
        3'd2:    push_strb = 4'b0011;
        default: push_strb = 4'b0111;
      endcase
      lane_d = 2'd0;
      word_d = '0;
    end else begin
      lane_d = k[1:0];
      word_d = packed_word;
    end

    if (do_flush) flush_seen_d = 1'b1;

    // Address counts accepted words only, so a dropped word consumes no address.
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      addr_d   = addr_q + 1'b1;
    end
    if (push && full && !pop) begin
      ovf_d = 1'b1;
    end else if (push) begin
      mem_d[wr_ptr_q] = {push_strb, push_word};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(push && !(full && !pop)) - CNT_W'(pop);

    done_d = done_q | (flush_seen_q && (lane_q == 2'd0) && (count_q == '0));

    if (start) begin
      lane_d       = 2'd0;
      word_d       = '0;
      addr_d       = base_addr;
      sat_d        = 1'b0;
      ovf_d        = 1'b0;
      flush_seen_d = 1'b0;
      done_d       = 1'b0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q       <= '0;
      word_q       <= '0;
      addr_q       <= '0;
      sat_q        <= 1'b0;
      ovf_q        <= 1'b0;
      flush_seen_q <= 1'b0;
      done_q       <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      lane_q       <= lane_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      sat_q        <= sat_d;
      ovf_q        <= ovf_d;
      flush_seen_q <= flush_seen_d;
      done_q       <= done_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_result_packer.sv
// Scoreboard bench for result_packer: a reference packer queues expected words as results
// are driven; a monitor compares every accepted word in order.
module tb_result_packer;
  localparam int RW = 20;
  localparam int AW = 12;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset, start, en_relu, result_valid, flush, wr_ready;
  logic [AW-1:0] base_addr;
  logic [RW-1:0] result_data;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;
  logic [AW-1:0] wr_addr;
  logic          wr_valid, sat_flag, fifo_ovrflow, done;

  always #5 clk = ~clk;

  result_packer #(.RESULT_DWIDTH(RW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .en_relu(en_relu),
    .result_data(result_data), .result_valid(result_valid), .flush(flush),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_addr(wr_addr), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .sat_flag(sat_flag), .fifo_ovrflow(fifo_ovrflow), .done(done)
  );

  typedef struct packed {
    logic [31:0]   data;
    logic [3:0]    strb;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  int            m_lane;
  logic [31:0]   m_word;
  logic [AW-1:0] m_base;
  int            m_words;
  bit            m_sat;

  function automatic logic [8:0] conv(int v, bit relu);
    int r;
    r = (relu && v < 0) ? 0 : v;
    if (r > 127)  return {1'b1, 8'h7F};
    if (r < -128) return {1'b1, 8'h80};
    return {1'b0, 8'(r)};
  endfunction

  task automatic model_clear(logic [AW-1:0] base);
    m_base = base; m_words = 0; m_lane = 0; m_word = '0; m_sat = 1'b0;
    sb.delete();
  endtask

  task automatic model_push(logic [31:0] w, logic [3:0] s);
    exp_t e;
    e.data = w; e.strb = s; e.addr = m_base + AW'(m_words);
    sb.push_back(e);
    m_words++;
  endtask

  task automatic model_result(int v);
    logic [8:0] c;
    c = conv(v, en_relu);
    m_sat = m_sat | c[8];
    m_word[8*m_lane +: 8] = c[7:0];
    m_lane++;
    if (m_lane == 4) begin
      model_push(m_word, 4'hF);
      m_lane = 0; m_word = '0;
    end
  endtask

  task automatic model_flush();
    if (m_lane > 0) begin
      model_push(m_word, 4'((1 << m_lane) - 1));
      m_lane = 0; m_word = '0;
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic send(int v, bit fl);
    result_valid = 1'b1; result_data = RW'(v); flush = fl;
    model_result(v);
    if (fl) model_flush();
    cycle();
    result_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic send_flush();
    flush = 1'b1;
    model_flush();
    cycle();
    flush = 1'b0;
  endtask

  task automatic do_start(logic [AW-1:0] base);
    start = 1'b1; base_addr = base;
    cycle();
    start = 1'b0;
    model_clear(base);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    model_clear('0);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset && wr_valid === 1'b1 && wr_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got data=%h strb=%h addr=%h, required no write",
                   wr_data, wr_strb, wr_addr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({wr_data, wr_strb, wr_addr} !== {e.data, e.strb, e.addr}) begin
            errors++;
            $display("FAIL scoreboard_word: got data=%h strb=%h addr=%h, required data=%h strb=%h addr=%h",
                     wr_data, wr_strb, wr_addr, e.data, e.strb, e.addr);
          end
        end
      end
    end
  endtask

  task automatic wait_drain(int budget);
    int n = 0;
    while ((sb.size() != 0 || wr_valid !== 1'b0) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (sb.size() != 0 || wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending words wr_valid=%b, required 0 and 0",
               sb.size(), wr_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base_addr = '0; en_relu = 1'b0; result_data = '0;
    result_valid = 1'b0; flush = 1'b0; wr_ready = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    model_clear('0);
    checks++;
    if ({wr_valid, wr_data, wr_strb, wr_addr, sat_flag, fifo_ovrflow, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h strb=%h addr=%h sat=%b ovf=%b done=%b, required all 0",
               wr_valid, wr_data, wr_strb, wr_addr, sat_flag, fifo_ovrflow, done);
    end
  endtask

  task automatic test_basic();
    wr_ready = 1'b1; en_relu = 1'b0;
    do_start(12'h010);
    send(1, 0); send(2, 0); send(3, 0);
    checks++;
    if (wr_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early_valid: got %b, required 0", wr_valid);
    end
    send(4, 0);
    checks++;
    if ({wr_valid, wr_data, wr_strb, wr_addr} !== {1'b1, 32'h04030201, 4'hF, 12'h010}) begin
      errors++;
      $display("FAIL basic_word: got valid=%b data=%h strb=%h addr=%h, required 1 04030201 f 010",
               wr_valid, wr_data, wr_strb, wr_addr);
    end
    wait_drain(20);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_before_flush: got %b, required 0", done);
    end
    send_flush();
    cycle();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL done_empty_flush: got %b, required 1", done);
    end
  endtask

  task automatic test_saturate();
    wr_ready = 1'b1; en_relu = 1'b0;
    do_start(12'h020);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_cleared_by_start: got %b, required 0", done);
    end
    send(300, 0); send(-300, 0); send(5, 0);
    send_flush();
    checks++;
    if ({wr_valid, wr_data, wr_strb, sat_flag, done} !== {1'b1, 32'h0005807F, 4'b0111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sat_partial: got valid=%b data=%h strb=%b sat=%b done=%b, required 1 0005807f 0111 1 0",
               wr_valid, wr_data, wr_strb, sat_flag, done);
    end
    cycle();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_early: got %b, required 0", done);
    end
    cycle();
    checks++;
    if (done !== 1'b1 || sb.size() != 0) begin
      errors++; $display("FAIL done_after_accept: got done=%b pending=%0d, required 1 and 0", done, sb.size());
    end
  endtask

  task automatic test_relu();
    wr_ready = 1'b1; en_relu = 1'b1;
    do_start(12'h030);
    send(-7, 0); send(9, 0); send(-1, 0); send(0, 0);
    checks++;
    if ({wr_valid, wr_data, sat_flag} !== {1'b1, 32'h00000900, 1'b0}) begin
      errors++;
      $display("FAIL relu_word: got valid=%b data=%h sat=%b, required 1 00000900 0",
               wr_valid, wr_data, sat_flag);
    end
    send(-5000, 0); send(-200, 1);
    wait_drain(20);
    checks++;
    if (sat_flag !== 1'b0) begin
      errors++; $display("FAIL relu_no_sat: got %b, required 0", sat_flag);
    end
    en_relu = 1'b0;
  endtask

  task automatic test_same_cycle();
    wr_ready = 1'b1; en_relu = 1'b0;
    do_start(12'h040);
    send(10, 0); send(20, 0); send(30, 1);
    checks++;
    if ({wr_valid, wr_data, wr_strb, wr_addr} !== {1'b1, 32'h001E140A, 4'b0111, 12'h040}) begin
      errors++;
      $display("FAIL same_cycle_partial: got valid=%b data=%h strb=%b addr=%h, required 1 001e140a 0111 040",
               wr_valid, wr_data, wr_strb, wr_addr);
    end
    send(1, 0); send(2, 0); send(3, 0); send(4, 1);
    checks++;
    if ({wr_data, wr_strb} !== {32'h04030201, 4'hF}) begin
      errors++;
      $display("FAIL same_cycle_full: got data=%h strb=%h, required 04030201 f", wr_data, wr_strb);
    end
    repeat (3) cycle();
    wait_drain(20);
  endtask

  task automatic test_overflow();
    en_relu = 1'b0;
    do_start(12'h100);
    wr_ready = 1'b0;
    for (int i = 1; i <= 20; i++) send(i, 0);
    void'(sb.pop_back());
    m_words--;
    checks++;
    if ({fifo_ovrflow, wr_valid, wr_addr, wr_data} !== {1'b1, 1'b1, 12'h100, 32'h04030201}) begin
      errors++;
      $display("FAIL overflow_state: got ovf=%b valid=%b addr=%h data=%h, required 1 1 100 04030201",
               fifo_ovrflow, wr_valid, wr_addr, wr_data);
    end
    repeat (3) cycle();
    checks++;
    if ({wr_addr, wr_data, wr_strb} !== {12'h100, 32'h04030201, 4'hF}) begin
      errors++;
      $display("FAIL stall_hold: got addr=%h data=%h strb=%h, required 100 04030201 f",
               wr_addr, wr_data, wr_strb);
    end
    wr_ready = 1'b1;
    wait_drain(30);
  endtask

  task automatic test_wrap();
    wr_ready = 1'b1; en_relu = 1'b0;
    do_start(12'hFFF);
    for (int i = 0; i < 4; i++) send(i + 40, 0);
    checks++;
    if (wr_addr !== 12'hFFF) begin
      errors++; $display("FAIL wrap_first_addr: got %h, required fff", wr_addr);
    end
    for (int i = 0; i < 4; i++) send(i + 50, 0);
    wait_drain(20);
    checks++;
    if (wr_addr !== 12'h001) begin
      errors++; $display("FAIL wrap_final_addr: got %h, required 001", wr_addr);
    end
  endtask

  task automatic test_back_to_back();
    do_start(12'h200);
    for (int i = 0; i < 60; i++) begin
      wr_ready = (i % 3 != 2);
      if (i % 5 != 4) begin
        en_relu = 1'($urandom_range(0, 1));
        send(int'($urandom_range(0, 1023)) - 512, 0);
      end else begin
        cycle();
      end
    end
    send_flush();
    wr_ready = 1'b1;
    wait_drain(40);
    cycle(); cycle();
    checks++;
    if ({sat_flag, fifo_ovrflow, done} !== {m_sat, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL stream_flags: got sat=%b ovf=%b done=%b, required %b 0 1",
               sat_flag, fifo_ovrflow, done, m_sat);
    end
    en_relu = 1'b0;
  endtask

  task automatic test_reset_mid();
    wr_ready = 1'b1; en_relu = 1'b0;
    do_start(12'h050);
    send(300, 0); send(2, 0);
    do_reset();
    checks++;
    if ({wr_valid, wr_data, wr_strb, wr_addr, sat_flag, fifo_ovrflow, done} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got valid=%b data=%h strb=%h addr=%h sat=%b ovf=%b done=%b, required all 0",
               wr_valid, wr_data, wr_strb, wr_addr, sat_flag, fifo_ovrflow, done);
    end
    repeat (5) cycle();
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    checks++;
    if ({wr_valid, wr_addr, wr_data} !== {1'b1, 12'h000, 32'h04030201}) begin
      errors++;
      $display("FAIL no_start_base0: got valid=%b addr=%h data=%h, required 1 000 04030201",
               wr_valid, wr_addr, wr_data);
    end
    wait_drain(20);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_saturate();
    test_relu();
    test_same_cycle();
    test_overflow();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    repeat (2) cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
